// File: rtl/decode_ctrl_pipe_pkg.sv
// RV32I control-word types shared by the decode stage and its sub-decoder.
package rv32i_types;

    localparam int unsigned INSTR_W = 32;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;
    localparam logic [6:0] FUNCT7_MEXT = 7'h01;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_SR   = 3'd5;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq = 3'd0, bne = 3'd1, blt = 3'd4, bge = 3'd5, bltu = 3'd6, bgeu = 3'd7
    } branch_funct3_t;

    typedef enum logic [2:0] {
        alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
    } alu_ops;

    typedef enum logic [3:0] {
        rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4, rf_lb, rf_lbu, rf_lh, rf_lhu
    } regfilemux_sel_t;

    typedef enum logic { alumux1_rs1, alumux1_pc } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2
    } alumux2_sel_t;

    typedef enum logic { cmpmux_rs2, cmpmux_i_imm } cmpmux_sel_t;
    typedef enum logic { marmux_pc, marmux_alu } marmux_sel_t;

    typedef enum logic [2:0] {
        mul, mulh, mulhsu, mulhu, div, divu, rem, remu
    } muldiv_funct3_t;

    typedef struct packed {
        logic [6:0]      opcode;
        alu_ops          aluop;
        branch_funct3_t  cmpop;
        logic            load_regfile;
        regfilemux_sel_t regfilemux_sel;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        cmpmux_sel_t     cmpmux_sel;
        marmux_sel_t     marmux_sel;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      mem_funct3;
    } rv32_ctrl_t;

    typedef struct packed {
        rv32_ctrl_t      base;
        logic            muldiv_en;
        muldiv_funct3_t  muldiv_op;
        logic            illegal;
    } rv32_ctrl_ext_t;

endpackage

// File: rtl/ctrl_decode_ext.sv
// Combinational RV32I(+M) decoder producing the extended control word.
module ctrl_decode_ext
    import rv32i_types::*;
#(
    parameter bit EN_MEXT = 1'b1
) (
    input  logic [INSTR_W-1:0] instr_i,
    output rv32_ctrl_ext_t     ctrl_o_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_c;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign unused_c = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        rv32_ctrl_ext_t c;
        logic           bad;
        c             = '0;
        bad           = 1'b0;
        c.base.opcode = opcode;
        case (opcode)
            op_lui: begin
                c.base.load_regfile   = 1'b1;
                c.base.regfilemux_sel = rf_u_imm;
            end
            op_auipc: begin
                c.base.load_regfile = 1'b1;
                c.base.alumux1_sel  = alumux1_pc;
                c.base.alumux2_sel  = alumux2_u_imm;
            end
            op_jal: begin
                c.base.load_regfile   = 1'b1;
                c.base.regfilemux_sel = rf_pc_plus4;
                c.base.alumux1_sel    = alumux1_pc;
                c.base.alumux2_sel    = alumux2_j_imm;
            end
            op_jalr: begin
                bad                   = (funct3 != 3'd0);
                c.base.load_regfile   = 1'b1;
                c.base.regfilemux_sel = rf_pc_plus4;
            end
            op_br: begin
                bad                = (funct3[2:1] == 2'b01);
                c.base.alumux1_sel = alumux1_pc;
                c.base.alumux2_sel = alumux2_b_imm;
                c.base.cmpop       = branch_funct3_t'(funct3);
            end
            op_load: begin
                c.base.load_regfile = 1'b1;
                c.base.mem_read     = 1'b1;
                c.base.marmux_sel   = marmux_alu;
                c.base.mem_funct3   = funct3;
                case (funct3)
                    3'd0:    c.base.regfilemux_sel = rf_lb;
                    3'd1:    c.base.regfilemux_sel = rf_lh;
                    3'd2:    c.base.regfilemux_sel = rf_lw;
                    3'd4:    c.base.regfilemux_sel = rf_lbu;
                    3'd5:    c.base.regfilemux_sel = rf_lhu;
                    default: bad = 1'b1;
                endcase
            end
            op_store: begin
                bad                = (funct3 > 3'd2);
                c.base.mem_write   = 1'b1;
                c.base.marmux_sel  = marmux_alu;
                c.base.alumux2_sel = alumux2_s_imm;
                c.base.mem_funct3  = funct3;
            end
            op_imm: begin
                c.base.load_regfile = 1'b1;
                case (funct3)
                    F3_SLT, F3_SLTU: begin
                        c.base.cmpop          = (funct3 == F3_SLT) ? blt : bltu;
                        c.base.cmpmux_sel     = cmpmux_i_imm;
                        c.base.regfilemux_sel = rf_br_en;
                    end
                    F3_SLL: begin
                        bad          = (funct7 != FUNCT7_BASE);
                        c.base.aluop = alu_sll;
                    end
                    F3_SR: begin
                        bad          = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                        c.base.aluop = funct7[5] ? alu_sra : alu_srl;
                    end
                    default: c.base.aluop = alu_ops'(funct3);
                endcase
            end
            op_reg: begin
                c.base.load_regfile = 1'b1;
                c.base.alumux2_sel  = alumux2_rs2;
                // funct7=0x01 selects the M extension; otherwise only base/alt encodings exist
                if (funct7 == FUNCT7_MEXT) begin
                    bad         = !EN_MEXT;
                    c.muldiv_en = 1'b1;
                    c.muldiv_op = muldiv_funct3_t'(funct3);
                end else if ((funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT)) begin
                    bad = 1'b1;
                end else if ((funct7 == FUNCT7_ALT) && (funct3 != F3_ADD) && (funct3 != F3_SR)) begin
                    bad = 1'b1;
                end else begin
                    case (funct3)
                        F3_ADD: c.base.aluop = funct7[5] ? alu_sub : alu_add;
                        F3_SR:  c.base.aluop = funct7[5] ? alu_sra : alu_srl;
                        F3_SLT, F3_SLTU: begin
                            c.base.cmpop          = (funct3 == F3_SLT) ? blt : bltu;
                            c.base.regfilemux_sel = rf_br_en;
                        end
                        default: c.base.aluop = alu_ops'(funct3);
                    endcase
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            c             = '0;
            c.base.opcode = opcode;
            c.illegal     = 1'b1;
        end
        ctrl_o_c = c;
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode stage: decoder feeding a head register plus one skid entry, with perf counters.
module decode_ctrl_pipe
    import rv32i_types::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          EN_MEXT = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output rv32_ctrl_ext_t       out_ctrl,
    output logic [XLEN-1:0]      out_pc,
    output logic [CNT_W-1:0]     issue_cnt,
    output logic [CNT_W-1:0]     illegal_cnt
);

    rv32_ctrl_ext_t   dec_ctrl_c;
    logic             accept_c, consume_c, head_free_c;

    logic             head_vld_q, head_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
    rv32_ctrl_ext_t   head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [XLEN-1:0]  head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0] issue_q, issue_d, illegal_q, illegal_d;

    ctrl_decode_ext #(.EN_MEXT(EN_MEXT)) u_dec (
        .instr_i  (in_instr),
        .ctrl_o_c (dec_ctrl_c)
    );

    assign accept_c    = in_valid && rdy_q;
    assign consume_c   = head_vld_q && out_ready;
    assign head_free_c = !head_vld_q || out_ready;

    // Next-state for head/skid and counters
    always_comb begin
        head_vld_d  = head_vld_q;
        head_ctrl_d = head_ctrl_q;
        head_pc_d   = head_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_pc_d   = skid_pc_q;
        issue_d     = issue_q;
        illegal_d   = illegal_q;

        if (consume_c) begin
            if (issue_q != '1) issue_d = issue_q + CNT_W'(1);
            if (head_ctrl_q.illegal && (illegal_q != '1)) illegal_d = illegal_q + CNT_W'(1);
        end

        if (flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // in_ready is low while skid holds an entry, so no accept competes here
            if (head_free_c) begin
                head_vld_d  = 1'b1;
                head_ctrl_d = skid_ctrl_q;
                head_pc_d   = skid_pc_q;
                skid_vld_d  = 1'b0;
            end
        end else if (accept_c) begin
            if (head_free_c) begin
                head_vld_d  = 1'b1;
                head_ctrl_d = dec_ctrl_c;
                head_pc_d   = in_pc;
            end else begin
                skid_vld_d  = 1'b1;
                skid_ctrl_d = dec_ctrl_c;
                skid_pc_d   = in_pc;
            end
        end else if (head_free_c) begin
            head_vld_d = 1'b0;
        end

        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld_q  <= 1'b0;
            head_ctrl_q <= '0;
            head_pc_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_pc_q   <= '0;
            rdy_q       <= 1'b1;
            issue_q     <= '0;
            illegal_q   <= '0;
        end else begin
            head_vld_q  <= head_vld_d;
            head_ctrl_q <= head_ctrl_d;
            head_pc_q   <= head_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_pc_q   <= skid_pc_d;
            rdy_q       <= rdy_d;
            issue_q     <= issue_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = head_vld_q;
    assign out_ctrl    = head_ctrl_q;
    assign out_pc      = head_pc_q;
    assign issue_cnt   = issue_q;
    assign illegal_cnt = illegal_q;

endmodule
